jesd_rx_link_ctrl: RTL



---
 rtl/jesd_rx_link_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/jesd_rx_link_ctrl.sv
// JESD204B receive link controller: CGS -> ILAS -> DATA sequencing on LMFC boundaries.
// Optional JESD_RX_ERR_RESYNC_EN builds the per-multiframe error-threshold resync.
module jesd_rx_link_ctrl #(
  parameter int unsigned NUM_LANES          = 4,
  parameter int unsigned RELEASE_DELAY_LMFC = 1,
  parameter int unsigned ILAS_MULTIFRAMES   = 4,
  parameter int unsigned ILAS_TIMEOUT_LMFC  = 8,
  parameter int unsigned ERR_THRESHOLD      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 lmfc_clk_i,
  input  logic [NUM_LANES-1:0] lane_cgs_done_i,
  input  logic [NUM_LANES-1:0] lane_ilas_start_i,
  input  logic [NUM_LANES-1:0] lane_err_i,
  output logic                 sync_no,
  output logic [1:0]           state_o,
  output logic                 data_valid_o,
  output logic                 link_err_o,
  output logic [7:0]           err_count_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCgs  = 2'b01,
    StIlas = 2'b10,
    StData = 2'b11
  } state_e;

  localparam logic [3:0] RelDly  = 4'(RELEASE_DELAY_LMFC);
  localparam logic [3:0] IlasMf  = 4'(ILAS_MULTIFRAMES);
  localparam logic [3:0] IlasTmo = 4'(ILAS_TIMEOUT_LMFC);

  state_e               state_q;
  logic [3:0]           bnd_q;
  logic [3:0]           mf_q;
  logic [3:0]           tmo_q;
  logic [NUM_LANES-1:0] ilas_seen_q;
  logic [NUM_LANES-1:0] ilas_seen_d;
  logic                 all_cgs;
  logic                 all_seen;
  logic                 thr_hit;
  logic [8:0]           pop;
  logic [7:0]           err_count_d;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > 10'd255) ? 8'hff : s[7:0];
  endfunction

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop = pop + 9'(lane_err_i[i]);
    end
  end

  assign all_cgs     = &lane_cgs_done_i;
  // A start pulse coinciding with an LMFC pulse counts as seen before that pulse is evaluated.
  assign ilas_seen_d = ilas_seen_q | lane_ilas_start_i;
  assign all_seen    = &ilas_seen_d;
  assign err_count_d = (state_q == StIdle || !enable_i) ? 8'd0 : sat_add(err_count_o, pop);
  assign state_o     = state_q;

`ifdef JESD_RX_ERR_RESYNC_EN
  localparam logic [7:0] ErrThr = 8'(ERR_THRESHOLD);

  logic [7:0] mf_err_q;
  logic [7:0] mf_err_d;

  // Errors coinciding with the LMFC pulse open the new multiframe's count.
  assign mf_err_d = sat_add(lmfc_clk_i ? 8'd0 : mf_err_q, pop);
  assign thr_hit  = (mf_err_d >= ErrThr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mf_err_q <= 8'd0;
    end else if (state_q == StIdle || !enable_i) begin
      mf_err_q <= 8'd0;
    end else begin
      mf_err_q <= mf_err_d;
    end
  end
`else
  logic unused_err_thr;
  assign unused_err_thr = ^ERR_THRESHOLD;
  assign thr_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sync_no      <= 1'b0;
      data_valid_o <= 1'b0;
      link_err_o   <= 1'b0;
      err_count_o  <= 8'd0;
      bnd_q        <= 4'd0;
      mf_q         <= 4'd0;
      tmo_q        <= 4'd0;
      ilas_seen_q  <= '0;
    end else begin
      link_err_o  <= 1'b0;
      err_count_o <= err_count_d;
      if (!enable_i) begin
        state_q      <= StIdle;
        sync_no      <= 1'b0;
        data_valid_o <= 1'b0;
        bnd_q        <= 4'd0;
        mf_q         <= 4'd0;
        tmo_q        <= 4'd0;
        ilas_seen_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q     <= StCgs;
            bnd_q       <= 4'd0;
            mf_q        <= 4'd0;
            tmo_q       <= 4'd0;
            ilas_seen_q <= '0;
          end
          StCgs: begin
            if (!all_cgs) begin
              bnd_q <= 4'd0;
            end else if (lmfc_clk_i) begin
              if (bnd_q + 4'd1 >= RelDly) begin
                state_q <= StIlas;
                sync_no <= 1'b1;
                bnd_q   <= 4'd0;
              end else begin
                bnd_q <= bnd_q + 4'd1;
              end
            end
          end
          StIlas, StData: begin
            if (!all_cgs || thr_hit) begin
              state_q      <= StCgs;
              sync_no      <= 1'b0;
              data_valid_o <= 1'b0;
              link_err_o   <= 1'b1;
              bnd_q        <= 4'd0;
              mf_q         <= 4'd0;
              tmo_q        <= 4'd0;
              ilas_seen_q  <= '0;
            end else if (state_q == StIlas) begin
              ilas_seen_q <= ilas_seen_d;
              if (lmfc_clk_i && tmo_q != 4'hf) begin
                tmo_q <= tmo_q + 4'd1;
              end
              if (lmfc_clk_i && all_seen) begin
                mf_q <= mf_q + 4'd1;
                if (mf_q + 4'd1 >= IlasMf) begin
                  state_q      <= StData;
                  data_valid_o <= 1'b1;
                end
              end else if (lmfc_clk_i && (tmo_q + 4'd1 >= IlasTmo)) begin
                state_q     <= StCgs;
                sync_no     <= 1'b0;
                link_err_o  <= 1'b1;
                bnd_q       <= 4'd0;
                mf_q        <= 4'd0;
                tmo_q       <= 4'd0;
                ilas_seen_q <= '0;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
